// File: rtl/regs_banked.sv
// regs_banked: 16-entry register file with mode-banked r13/r14, PC incrementer, NZCV flags, two write ports.
// Optional same-cycle write-to-read forwarding is enabled by defining REGS_BYPASS_EN.
module regs_banked #(
    parameter int              DATA_W   = 32,
    parameter int              NUM_RD   = 3,
    parameter int              PC_STEP  = 4,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     we,
    input  logic [3:0]               sel_in,
    input  logic [DATA_W-1:0]        in_reg,
    input  logic                     we_ld,
    input  logic [3:0]               sel_ld,
    input  logic [DATA_W-1:0]        in_ld,
    input  logic [4*NUM_RD-1:0]      sel_rd,
    output logic [DATA_W*NUM_RD-1:0] rd_data,
    input  logic                     mode,
    input  logic                     pc_inc,
    input  logic                     flags_we,
    input  logic [3:0]               flags_in,
    output logic [3:0]               flags_out,
    output logic [DATA_W-1:0]        pc_out
);
    logic [DATA_W-1:0] gpr [0:12];
    logic [DATA_W-1:0] r13_b [0:1];
    logic [DATA_W-1:0] r14_b [0:1];
    logic [15:0]       ld_hit;
    logic [15:0]       wr_hit;

    // per-index write decode; the load port owns the index on a collision
    always_comb begin
        ld_hit = '0;
        wr_hit = '0;
        for (int i = 0; i < 16; i++) begin
            ld_hit[i] = we_ld && sel_ld == 4'(i);
            wr_hit[i] = ld_hit[i] || (we && sel_in == 4'(i));
        end
    end

    // register, bank, PC and flag state; banked writes land in the current mode's copy
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 13; i++) gpr[i] <= '0;
            for (int i = 0; i < 2; i++) begin
                r13_b[i] <= '0;
                r14_b[i] <= '0;
            end
            pc_out    <= RESET_PC;
            flags_out <= '0;
        end else begin
            for (int i = 0; i < 13; i++)
                if (wr_hit[i]) gpr[i] <= ld_hit[i] ? in_ld : in_reg;
            if (wr_hit[13]) r13_b[mode] <= ld_hit[13] ? in_ld : in_reg;
            if (wr_hit[14]) r14_b[mode] <= ld_hit[14] ? in_ld : in_reg;
            if (wr_hit[15])  pc_out <= ld_hit[15] ? in_ld : in_reg;
            else if (pc_inc) pc_out <= pc_out + DATA_W'(PC_STEP);
            if (flags_we) flags_out <= flags_in;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [3:0]        s;
        logic [DATA_W-1:0] stored;
        assign s = sel_rd[4*k +: 4];
        // stored value for this port, banked indices resolved through the live mode
        always_comb stored = s == 4'd15 ? pc_out :
                             s == 4'd14 ? r14_b[mode] :
                             s == 4'd13 ? r13_b[mode] : gpr[s];
`ifdef REGS_BYPASS_EN
        assign rd_data[DATA_W*k +: DATA_W] = !wr_hit[s] ? stored : ld_hit[s] ? in_ld : in_reg;
`else
        assign rd_data[DATA_W*k +: DATA_W] = stored;
`endif
    end
endmodule

// File: tb/tb_regs_banked.sv
// tb_regs_banked: table-driven check of regs_banked plus hand sequences for bypass and async reset.
module tb_regs_banked;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        we = 1'b0, we_ld = 1'b0, mode = 1'b0, pc_inc = 1'b0, flags_we = 1'b0;
    logic [3:0]  sel_in = '0, sel_ld = '0, flags_in = '0;
    logic [31:0] in_reg = '0, in_ld = '0;
    logic [11:0] sel_rd = '0;
    logic [95:0] rd_data;
    logic [3:0]  flags_out;
    logic [31:0] pc_out;
    int          n_chk = 0, n_pass = 0;
    logic        bypass;

    typedef struct {
        logic        we;
        logic [3:0]  sel_in;
        logic [31:0] in_reg;
        logic        we_ld;
        logic [3:0]  sel_ld;
        logic [31:0] in_ld;
        logic        mode;
        logic        pc_inc;
        logic        flags_we;
        logic [3:0]  flags_in;
        logic [11:0] sel_rd;
        logic [95:0] exp_rd;
        logic [31:0] exp_pc;
        logic [3:0]  exp_flags;
    } vec_t;

    vec_t vecs[$];

    regs_banked dut (
        .clock(clock), .reset_n(reset_n), .we(we), .sel_in(sel_in), .in_reg(in_reg),
        .we_ld(we_ld), .sel_ld(sel_ld), .in_ld(in_ld), .sel_rd(sel_rd), .rd_data(rd_data),
        .mode(mode), .pc_inc(pc_inc), .flags_we(flags_we), .flags_in(flags_in),
        .flags_out(flags_out), .pc_out(pc_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic quiet();
        we = 1'b0;
        we_ld = 1'b0;
        pc_inc = 1'b0;
        flags_we = 1'b0;
    endtask

    initial begin
`ifdef REGS_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        //          we sel  in_reg        ld sel  in_ld         md inc fwe fin    sel_rd               exp_rd                                       pc             flags
        vecs.push_back('{1, 4'd0, 32'h12345678, 0, 4'd0, 32'h0, 0, 0, 0, 4'h0, {4'd2, 4'd1, 4'd0}, {32'h0, 32'h0, 32'h12345678}, 32'h0, 4'h0});
        vecs.push_back('{1, 4'd1, 32'h87654321, 0, 4'd0, 32'h0, 0, 0, 0, 4'h0, {4'd2, 4'd1, 4'd0}, {32'h0, 32'h87654321, 32'h12345678}, 32'h0, 4'h0});
        vecs.push_back('{1, 4'd5, 32'hAAAA0000, 1, 4'd5, 32'h5555FFFF, 0, 0, 0, 4'h0, {4'd1, 4'd0, 4'd5}, {32'h87654321, 32'h12345678, 32'h5555FFFF}, 32'h0, 4'h0});
        vecs.push_back('{1, 4'd6, 32'h66, 1, 4'd7, 32'h77, 0, 0, 0, 4'h0, {4'd7, 4'd6, 4'd5}, {32'h77, 32'h66, 32'h5555FFFF}, 32'h0, 4'h0});
        vecs.push_back('{0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 1, 0, 4'h0, {4'd15, 4'd15, 4'd15}, {32'h4, 32'h4, 32'h4}, 32'h4, 4'h0});
        vecs.push_back('{0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 1, 0, 4'h0, {4'd15, 4'd15, 4'd15}, {32'h8, 32'h8, 32'h8}, 32'h8, 4'h0});
        vecs.push_back('{0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 1, 0, 4'h0, {4'd15, 4'd0, 4'd1}, {32'hC, 32'h12345678, 32'h87654321}, 32'hC, 4'h0});
        vecs.push_back('{1, 4'd15, 32'hABCD1234, 0, 4'd0, 32'h0, 0, 1, 0, 4'h0, {4'd15, 4'd15, 4'd15}, {32'hABCD1234, 32'hABCD1234, 32'hABCD1234}, 32'hABCD1234, 4'h0});
        vecs.push_back('{0, 4'd0, 32'h0, 1, 4'd15, 32'hFFFFFFFC, 0, 0, 0, 4'h0, {4'd15, 4'd15, 4'd15}, {32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC}, 32'hFFFFFFFC, 4'h0});
        vecs.push_back('{0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 1, 0, 4'h0, {4'd15, 4'd15, 4'd15}, {32'h0, 32'h0, 32'h0}, 32'h0, 4'h0});
        vecs.push_back('{1, 4'd15, 32'h200, 1, 4'd15, 32'h100, 0, 1, 0, 4'h0, {4'd15, 4'd15, 4'd15}, {32'h100, 32'h100, 32'h100}, 32'h100, 4'h0});
        vecs.push_back('{1, 4'd13, 32'h1000, 0, 4'd0, 32'h0, 0, 0, 0, 4'h0, {4'd13, 4'd14, 4'd0}, {32'h1000, 32'h0, 32'h12345678}, 32'h100, 4'h0});
        vecs.push_back('{1, 4'd13, 32'h2000, 0, 4'd0, 32'h0, 1, 0, 0, 4'h0, {4'd13, 4'd13, 4'd13}, {32'h2000, 32'h2000, 32'h2000}, 32'h100, 4'h0});
        vecs.push_back('{0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 0, 0, 4'h0, {4'd13, 4'd5, 4'd6}, {32'h1000, 32'h5555FFFF, 32'h66}, 32'h100, 4'h0});
        vecs.push_back('{0, 4'd0, 32'h0, 1, 4'd14, 32'hE1, 1, 0, 0, 4'h0, {4'd14, 4'd13, 4'd0}, {32'hE1, 32'h2000, 32'h12345678}, 32'h100, 4'h0});
        vecs.push_back('{0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 0, 0, 4'h0, {4'd14, 4'd13, 4'd14}, {32'h0, 32'h1000, 32'h0}, 32'h100, 4'h0});
        vecs.push_back('{0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 0, 1, 4'hC, {4'd0, 4'd0, 4'd0}, {32'h12345678, 32'h12345678, 32'h12345678}, 32'h100, 4'hC});
        vecs.push_back('{0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 0, 0, 4'h3, {4'd0, 4'd0, 4'd0}, {32'h12345678, 32'h12345678, 32'h12345678}, 32'h100, 4'hC});
        vecs.push_back('{1, 4'd2, 32'hDEAD, 0, 4'd0, 32'h0, 0, 0, 1, 4'h5, {4'd2, 4'd2, 4'd2}, {32'hDEAD, 32'hDEAD, 32'hDEAD}, 32'h100, 4'h5});

        sel_rd = {4'd13, 4'd15, 4'd0};
        repeat (2) @(posedge clock);
        #1;
        chk("reset_pc_held", 96'(pc_out), 96'h0);
        chk("reset_flags_held", 96'(flags_out), 96'h0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("reset_rd", rd_data, 96'h0);
        chk("reset_pc", 96'(pc_out), 96'h0);
        chk("reset_flags", 96'(flags_out), 96'h0);

        foreach (vecs[i]) begin
            @(negedge clock);
            we = vecs[i].we; sel_in = vecs[i].sel_in; in_reg = vecs[i].in_reg;
            we_ld = vecs[i].we_ld; sel_ld = vecs[i].sel_ld; in_ld = vecs[i].in_ld;
            mode = vecs[i].mode; pc_inc = vecs[i].pc_inc;
            flags_we = vecs[i].flags_we; flags_in = vecs[i].flags_in;
            @(posedge clock);
            #1;
            quiet();
            sel_rd = vecs[i].sel_rd;
            #1;
            chk($sformatf("vec%0d_rd", i), rd_data, vecs[i].exp_rd);
            chk($sformatf("vec%0d_pc", i), 96'(pc_out), 96'(vecs[i].exp_pc));
            chk($sformatf("vec%0d_flags", i), 96'(flags_out), 96'(vecs[i].exp_flags));
        end

        @(negedge clock);
        we = 1'b1; sel_in = 4'd3; in_reg = 32'hBEEF; sel_rd = {4'd0, 4'd0, 4'd3};
        #1;
        chk("same_cycle_r3", 96'(rd_data[31:0]), bypass ? 96'hBEEF : 96'h0);
        @(posedge clock);
        #1;
        quiet();
        #1;
        chk("after_edge_r3", 96'(rd_data[31:0]), 96'hBEEF);

        @(negedge clock);
        mode = 1'b1; we = 1'b1; sel_in = 4'd13; in_reg = 32'h3333; sel_rd = {4'd0, 4'd0, 4'd13};
        #1;
        chk("same_cycle_r13_irq", 96'(rd_data[31:0]), bypass ? 96'h3333 : 96'h2000);
        @(posedge clock);
        #1;
        quiet();
        mode = 1'b0;
        #1;
        chk("r13_user_untouched", 96'(rd_data[31:0]), 96'h1000);

        @(negedge clock);
        we = 1'b1; sel_in = 4'd15; in_reg = 32'h40; sel_rd = {4'd0, 4'd0, 4'd15};
        #1;
        chk("same_cycle_pc_out_registered", 96'(pc_out), 96'h100);
        chk("same_cycle_r15_read", 96'(rd_data[31:0]), bypass ? 96'h40 : 96'h100);
        @(posedge clock);
        #1;
        quiet();
        #1;
        chk("pc_written", 96'(pc_out), 96'h40);

        @(negedge clock);
        we = 1'b1; sel_in = 4'd0; in_reg = 32'hFFFF; flags_we = 1'b1; flags_in = 4'hF;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_pc", 96'(pc_out), 96'h0);
        chk("async_reset_flags", 96'(flags_out), 96'h0);
        @(posedge clock);
        #1;
        quiet();
        mode = 1'b1;
        sel_rd = {4'd13, 4'd1, 4'd0};
        #1;
        chk("reset_drops_write", rd_data, 96'h0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("after_release_rd", rd_data, 96'h0);
        chk("after_release_flags", 96'(flags_out), 96'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
